// File: rtl/morse_round_ctrl.sv
// Round sequencer for the Morse trainer: plays a fixed number of rounds, each bounded
// by a shared ARM+WAIT timeout, then shows a pass/fail LED and tallies the score.
module morse_round_ctrl #(
  parameter int ROUNDS        = 8,
  parameter int ROUND_TIMEOUT = 250,
  parameter int RESULT_HOLD   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_i,
  input  logic       letter_ready_i,
  input  logic       result_valid_i,
  input  logic       result_ok_i,
  output logic       round_start_o,
  output logic       busy_o,
  output logic [3:0] score_o,
  output logic [3:0] round_o,
  output logic       led_ok_o,
  output logic       led_fail_o,
  output logic       done_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_SHOW = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST   = 8'(ROUND_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RESULT_HOLD - 1);
  localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [3:0] score, score_nxt;
  logic [3:0] round, round_nxt;
  logic       led_ok, led_ok_nxt;
  logic       led_fail, led_fail_nxt;
  logic       play_q;
  logic       play_rise;
  logic       enter_show;
  logic       verdict_ok;

  assign play_rise = play_i & ~play_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      score    <= '0;
      round    <= '0;
      led_ok   <= 1'b0;
      led_fail <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      score    <= score_nxt;
      round    <= round_nxt;
      led_ok   <= led_ok_nxt;
      led_fail <= led_fail_nxt;
      play_q   <= play_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    score_nxt    = score;
    round_nxt    = round;
    led_ok_nxt   = led_ok;
    led_fail_nxt = led_fail;
    enter_show   = 1'b0;
    verdict_ok   = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (play_rise) begin
          score_nxt = '0;
          round_nxt = '0;
          timer_nxt = '0;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        // A letter arriving on the last tick still moves to WAIT; the >= compare
        // below then expires it on the following cycle.
        if (letter_ready_i) begin
          timer_nxt = timer + 8'd1;
          state_nxt = S_WAIT;
        end else if (timer >= TO_LAST) begin
          enter_show = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      S_WAIT: begin
        if (result_valid_i) begin
          enter_show = 1'b1;
          verdict_ok = result_ok_i;
        end else if (timer >= TO_LAST) begin
          enter_show = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      S_SHOW: begin
        if (timer >= HOLD_LAST) begin
          led_ok_nxt   = 1'b0;
          led_fail_nxt = 1'b0;
          timer_nxt    = '0;
          state_nxt    = (round >= ROUNDS_L) ? S_DONE : S_ARM;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        timer_nxt    = '0;
        led_ok_nxt   = 1'b0;
        led_fail_nxt = 1'b0;
      end
    endcase

    if (enter_show) begin
      state_nxt    = S_SHOW;
      timer_nxt    = '0;
      round_nxt    = (round == 4'hF) ? round : round + 4'd1;
      led_ok_nxt   = verdict_ok;
      led_fail_nxt = ~verdict_ok;
      if (verdict_ok && score != 4'hF) score_nxt = score + 4'd1;
    end
  end

  assign round_start_o = (state == S_ARM) || (state == S_WAIT);
  assign busy_o        = (state == S_ARM) || (state == S_WAIT) || (state == S_SHOW);
  assign done_o        = (state == S_DONE);
  assign score_o       = score;
  assign round_o       = round;
  assign led_ok_o      = led_ok;
  assign led_fail_o    = led_fail;
endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl with ROUNDS=3, ROUND_TIMEOUT=10, RESULT_HOLD=4.
// Observed vector: {round_start, busy, done, led_ok, led_fail, score[3:0], round[3:0]}.
module tb_morse_round_ctrl;
  logic       clk;
  logic       rst;
  logic       play_i, letter_ready_i, result_valid_i, result_ok_i;
  logic       round_start_o, busy_o, led_ok_o, led_fail_o, done_o;
  logic [3:0] score_o, round_o;
  logic [12:0] obs, exp;
  int compared   = 0;
  int mismatched = 0;

  morse_round_ctrl #(.ROUNDS(3), .ROUND_TIMEOUT(10), .RESULT_HOLD(4)) dut (
    .clk(clk), .rst(rst), .play_i(play_i), .letter_ready_i(letter_ready_i),
    .result_valid_i(result_valid_i), .result_ok_i(result_ok_i),
    .round_start_o(round_start_o), .busy_o(busy_o), .score_o(score_o),
    .round_o(round_o), .led_ok_o(led_ok_o), .led_fail_o(led_fail_o), .done_o(done_o)
  );

  assign obs = {round_start_o, busy_o, done_o, led_ok_o, led_fail_o, score_o, round_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic rs, input logic b, input logic d,
                                     input logic ok, input logic fl,
                                     input logic [3:0] s, input logic [3:0] r);
    return {rs, b, d, ok, fl, s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; play_i = 0; letter_ready_i = 0; result_valid_i = 0; result_ok_i = 0;
    #3;
    exp = '0; compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL reset_async got %h want %h", obs, exp); end
    tick(); tick();
    exp = '0; compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL reset_held got %h want %h", obs, exp); end
    rst = 1'b0;
    tick(); tick();
    exp = '0; compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL idle_after_reset got %h want %h", obs, exp); end
  endtask

  task automatic test_full_game_pass();
    play_i = 1;
    tick();
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_to_arm got %h want %h", obs, exp); end
    for (int r = 1; r <= 3; r++) begin
      letter_ready_i = 1; tick(); letter_ready_i = 0;
      exp = mk(1,1,0,0,0,4'(r-1),4'(r-1)); compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL pass_wait r%0d got %h want %h", r, obs, exp); end
      result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
      for (int h = 0; h < 4; h++) begin
        exp = mk(0,1,0,1,0,4'(r),4'(r)); compared++;
        if (obs !== exp) begin mismatched++; $display("FAIL pass_show r%0d h%0d got %h want %h", r, h, obs, exp); end
        tick();
      end
      exp = (r < 3) ? mk(1,1,0,0,0,4'(r),4'(r)) : mk(0,0,1,0,0,3,3); compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL pass_after_show r%0d got %h want %h", r, obs, exp); end
    end
    play_i = 0;
    tick();
    exp = mk(0,0,1,0,0,3,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL done_hold got %h want %h", obs, exp); end
  endtask

  task automatic test_arm_timeout();
    play_i = 1; tick(); play_i = 0;
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL replay_from_done got %h want %h", obs, exp); end
    repeat (9) tick();
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL arm_tick9 got %h want %h", obs, exp); end
    tick();
    exp = mk(0,1,0,0,1,0,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL arm_timeout_show got %h want %h", obs, exp); end
    repeat (3) tick();
    exp = mk(0,1,0,0,1,0,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL arm_timeout_hold got %h want %h", obs, exp); end
    tick();
    exp = mk(1,1,0,0,0,0,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL arm_timeout_rearm got %h want %h", obs, exp); end
  endtask

  task automatic test_wait_timeout();
    tick();
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    repeat (7) tick();
    exp = mk(1,1,0,0,0,0,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL wait_tick9 got %h want %h", obs, exp); end
    tick();
    exp = mk(0,1,0,0,1,0,2); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL wait_timeout_show got %h want %h", obs, exp); end
    repeat (4) tick();
    exp = mk(1,1,0,0,0,0,2); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL wait_timeout_rearm got %h want %h", obs, exp); end
  endtask

  task automatic test_strobe_vs_timeout();
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    repeat (8) tick();
    exp = mk(1,1,0,0,0,0,2); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL race_tick9 got %h want %h", obs, exp); end
    result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
    exp = mk(0,1,0,1,0,1,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL race_strobe_wins got %h want %h", obs, exp); end
    repeat (4) tick();
    exp = mk(0,0,1,0,0,1,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL race_done got %h want %h", obs, exp); end
  endtask

  task automatic test_play_ignored();
    play_i = 1; tick(); play_i = 0;
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    play_i = 1; tick();
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_in_wait got %h want %h", obs, exp); end
    play_i = 0; result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
    play_i = 1; tick();
    exp = mk(0,1,0,1,0,1,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_in_show1 got %h want %h", obs, exp); end
    play_i = 0; tick(); play_i = 1; tick();
    exp = mk(0,1,0,1,0,1,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_in_show3 got %h want %h", obs, exp); end
    play_i = 0; tick();
    exp = mk(1,1,0,0,0,1,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_ign_rearm got %h want %h", obs, exp); end
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
    exp = mk(0,1,0,1,0,2,2); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL second_pass got %h want %h", obs, exp); end
    repeat (4) tick();
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    result_valid_i = 1; result_ok_i = 0; tick(); result_valid_i = 0;
    exp = mk(0,1,0,0,1,2,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL verdict_bad got %h want %h", obs, exp); end
    repeat (4) tick();
    exp = mk(0,0,1,0,0,2,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL done_score2 got %h want %h", obs, exp); end
    result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
    exp = mk(0,0,1,0,0,2,3); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL strobe_in_done got %h want %h", obs, exp); end
    play_i = 1; tick();
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL done_replay got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid_show();
    letter_ready_i = 1; tick(); letter_ready_i = 0;
    result_valid_i = 1; result_ok_i = 1; tick(); result_valid_i = 0; result_ok_i = 0;
    play_i = 0; tick();
    exp = mk(0,1,0,1,0,1,1); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL pre_reset_show got %h want %h", obs, exp); end
    #2 rst = 1'b1;
    #1;
    exp = '0; compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL reset_mid_show got %h want %h", obs, exp); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    exp = '0; compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL idle_after_mid_reset got %h want %h", obs, exp); end
    play_i = 1; tick();
    exp = mk(1,1,0,0,0,0,0); compared++;
    if (obs !== exp) begin mismatched++; $display("FAIL play_after_mid_reset got %h want %h", obs, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_game_pass();
    test_arm_timeout();
    test_wait_timeout();
    test_strobe_vs_timeout();
    test_play_ignored();
    test_reset_mid_show();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
- Game sequencer for the Morse trainer.
- Runs a fixed number of rounds. Each round it holds the display/decoder `start` line high, waits for the checker verdict or a timeout, then shows a pass/fail indication.
- Keeps score and round count, and flags game-over.
- Sits between the user "play" button and the existing seven-segment/decoder datapath, replacing the raw `ui_in[0]` start wiring.

Parameters:
- ROUNDS, 8: rounds per game; legal range 1..15.
- ROUND_TIMEOUT, 250: clk ticks allowed per round (ARM+WAIT combined) before an automatic fail; legal range 2..255. Default is 2.5 s at 100 Hz.
- RESULT_HOLD, 100: clk ticks that the pass/fail LED is shown between rounds; legal range 1..255.

Ports:
- clk  in  1  system clock (100 Hz tick domain)
- rst  in  1  asynchronous active-high reset
- play_i  in  1  user play button, level, already synchronised
- letter_ready_i  in  1  display has latched a new random letter
- result_valid_i  in  1  single-cycle verdict strobe from the checker
- result_ok_i  in  1  verdict; sampled only when result_valid_i=1
- round_start_o  out  1  drives display/decoder start; high only in ARM and WAIT
- busy_o  out  1  game in progress (ARM, WAIT, SHOW)
- score_o  out  4  correct rounds this game
- round_o  out  4  rounds completed this game
- led_ok_o  out  1  pass indication, high in SHOW after a pass
- led_fail_o  out  1  fail indication, high in SHOW after a fail or timeout
- done_o  out  1  high in DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; timer=0; play_q=0.
- Play edge detection:
  - play_q registers play_i every cycle.
  - play_rise = play_i & ~play_q.
  - play_rise is acted on only in IDLE and DONE; it is ignored in all other states.
- IDLE:
  - On play_rise: score=0, round=0, timer=0, next state=ARM.
- ARM:
  - round_start_o=1. Timer increments every cycle.
  - letter_ready_i=1 -> WAIT. The timer is not cleared, so the budget is shared with WAIT.
  - timer==ROUND_TIMEOUT-1 with letter_ready_i=0 -> SHOW with fail.
- WAIT:
  - round_start_o=1. Timer increments every cycle.
  - result_valid_i=1 -> SHOW with verdict=result_ok_i; score increments if ok.
  - timer==ROUND_TIMEOUT-1 with no strobe -> SHOW with fail.
  - If the strobe and the timeout occur in the same cycle, the strobe wins.
  - result_valid_i in any other state is ignored.
- SHOW:
  - round_start_o=0. Dropping start resets the decoder and display for the next letter.
  - On entry: round increments by 1, timer clears, verdict is latched to led_ok_o/led_fail_o. Exactly one LED is high.
  - After RESULT_HOLD cycles in SHOW:
    - LEDs clear.
    - round==ROUNDS -> DONE.
    - otherwise timer clears and next state is ARM.
- DONE:
  - done_o=1; score_o and round_o hold their final values.
  - On play_rise: clear score and round, go directly to ARM (same actions as IDLE+play).
- Latency:
  - play_rise to round_start_o=1: 1 cycle.
  - result_valid_i to LED high: 1 cycle, because LEDs are registered.
- Arithmetic:
  - score and round are 4-bit and saturate at 15; they cannot exceed ROUNDS by construction.
  - timer is 8-bit and never wraps, because every expiry compare happens before 255.
- Encoding:
  - Illegal state encodings return to IDLE on the next clock.
- Reset mid-game:
  - Reset forces IDLE immediately and zeroes all outputs, including round_start_o.

Test Plan:
- ROUNDS=3, HOLD=4. play rises; letter_ready one cycle later; result_valid with ok=1 in each round -> three ARM/WAIT/SHOW cycles, led_ok_o high 4 cycles each, final score_o=3, round_o=3, done_o=1, round_start_o=0.
- ROUND_TIMEOUT=10. letter_ready at cycle 2; no verdict -> SHOW entered after exactly 10 ticks of ARM+WAIT, led_fail_o=1, score_o unchanged.
- result_valid=1, ok=1 in the same cycle the timer hits 9 (TIMEOUT=10) -> pass recorded: led_ok_o=1, score increments.
- letter_ready held low -> ARM timeout fail after 10 ticks; round_o increments; next round re-enters ARM.
- play_i toggled during WAIT and SHOW -> no effect. Then, from DONE with score_o=2, play rises -> score_o=0, round_o=0, round_start_o=1 next cycle.
- rst pulsed asynchronously mid-SHOW with led_ok_o=1 -> all outputs 0 without waiting for a clock edge; after release, stays IDLE until a new play_rise.
